logic_fn_pipe: RTL and testbench

Parametrised, pipelined evaluator for the lab's two three-input logic functions. It applies the functions bitwise across WIDTH-bit operand vectors and returns both result vectors with their popcounts over a valid/ready stream. A saturation-free transaction counter is included, and an optional built-in truth-table sweep can self-check the datapath. It sits between the switch/stimulus front-end and the display/result logic in the lab top level.

---
 rtl/logic_fn_pkg.sv | 32 +++
 rtl/popcount.sv | 25 ++
 rtl/logic_fn_pipe.sv | 251 +++++++++++++++++++++++++
 tb/tb_logic_fn_pipe.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_fn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_fn_pkg
// Description : Shared definitions for the logic_fn_pipe evaluator:
//               - sweep_state_t : self-test FSM state encoding
//               - fn_x / fn_y   : scalar golden models of the two lab functions
//               - TXN_W         : width of the transaction counter
// Revision    : 1.0 - initial release
// ============================================================================
package logic_fn_pkg;

    localparam int TXN_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_t;

    // x = XNOR of c with (a OR b)
    function automatic logic fn_x(input logic a, input logic b, input logic c);
        return ~(c ^ (a | b));
    endfunction

    // (a|b) & (~(a&b) ^ (a|b)) collapses to a&b for every input combination
    function automatic logic fn_y(input logic a, input logic b);
        return a & b;
    endfunction

endpackage : logic_fn_pkg
`default_nettype wire

// File: rtl/popcount.sv
`default_nettype none
// ============================================================================
// Module      : popcount
// Description : Combinational population count of a WIDTH-bit vector.
// Ports       : bits  (in,  WIDTH) vector to count
//               count (out, CW)    number of set bits in 'bits'
// Revision    : 1.0 - initial release
// ============================================================================
module popcount #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [CW-1:0]    count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule : popcount
`default_nettype wire

// File: rtl/logic_fn_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_fn_pipe
// Description : Two-stage pipelined evaluator of the lab's two three-input
//               logic functions, applied bitwise over WIDTH-bit operands,
//               with popcounts of both results, valid/ready handshaking on
//               both sides and a wrapping 16-bit completed-transaction
//               counter.
//               Optional self-test (macro LOGIC_FN_SWEEP_EN): a sweep FSM
//               drives all eight truth-table rows through the datapath and
//               checks the results against the golden functions.
// Ports       : clk, rst_n                 clock, async active-low reset
//               in_valid/in_ready, a, b, c operand stream
//               out_valid/out_ready, x, y,
//               cnt_x, cnt_y               result stream with popcounts
//               txn_cnt                    completed output handshakes
//               sweep_start                one-cycle self-test request
//               sweep_busy/done/pass       self-test status
// Revision    : 1.0 - initial release
// ============================================================================
module logic_fn_pipe
    import logic_fn_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [WIDTH-1:0]  c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  x,
    output logic [WIDTH-1:0]  y,
    output logic [CW-1:0]     cnt_x,
    output logic [CW-1:0]     cnt_y,
    output logic [TXN_W-1:0]  txn_cnt,
    input  logic              sweep_start,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic              sweep_pass
);

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic              r_v1;
    logic              r_v2;
    logic [WIDTH-1:0]  r_s1_x;
    logic [WIDTH-1:0]  r_s1_y;
    logic [WIDTH-1:0]  r_s2_x;
    logic [WIDTH-1:0]  r_s2_y;
    logic [CW-1:0]     r_cnt_x;
    logic [CW-1:0]     r_cnt_y;
    logic [TXN_W-1:0]  r_txn_cnt;

    // Control shared with the (optional) sweep logic
    logic              w_busy;     // sweep owns the datapath
    logic              w_inject;   // sweep drives a truth-table row this cycle
    logic              w_start;    // sweep request is being accepted
    logic [2:0]        w_sweep_k;  // truth-table row being injected

    logic              w_en;
    logic              w_load;
    logic [WIDTH-1:0]  w_src_a;
    logic [WIDTH-1:0]  w_src_b;
    logic [WIDTH-1:0]  w_src_c;
    logic [WIDTH-1:0]  w_fx;
    logic [WIDTH-1:0]  w_fy;
    logic [CW-1:0]     w_pc_x;
    logic [CW-1:0]     w_pc_y;

    // During a sweep the pipeline must flow regardless of out_ready, since
    // sweep beats are never presented downstream.
    assign w_en      = ~r_v2 | out_ready | w_busy;
    // Blocking intake on the start edge keeps a user beat from slipping into
    // stage 1 alongside the first sweep row.
    assign in_ready  = w_en & ~w_busy & ~w_start;
    assign out_valid = r_v2 & ~w_busy;

    assign w_src_a = w_inject ? {WIDTH{w_sweep_k[2]}} : a;
    assign w_src_b = w_inject ? {WIDTH{w_sweep_k[1]}} : b;
    assign w_src_c = w_inject ? {WIDTH{w_sweep_k[0]}} : c;
    assign w_load  = w_inject | (in_valid & in_ready);

    always_comb begin
        w_fx = '0;
        w_fy = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_fx[i] = fn_x(w_src_a[i], w_src_b[i], w_src_c[i]);
            w_fy[i] = fn_y(w_src_a[i], w_src_b[i]);
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: function results
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_s1_x <= '0;
            r_s1_y <= '0;
        end else if (w_en) begin
            r_v1   <= w_load;
            r_s1_x <= w_fx;
            r_s1_y <= w_fy;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: results plus popcounts
    // ------------------------------------------------------------------
    popcount #(.WIDTH(WIDTH), .CW(CW)) u_pc_x (
        .bits  (r_s1_x),
        .count (w_pc_x)
    );

    popcount #(.WIDTH(WIDTH), .CW(CW)) u_pc_y (
        .bits  (r_s1_y),
        .count (w_pc_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_s2_x  <= '0;
            r_s2_y  <= '0;
            r_cnt_x <= '0;
            r_cnt_y <= '0;
        end else if (w_en) begin
            r_v2    <= r_v1;
            r_s2_x  <= r_s1_x;
            r_s2_y  <= r_s1_y;
            r_cnt_x <= w_pc_x;
            r_cnt_y <= w_pc_y;
        end
    end

    assign x     = r_s2_x;
    assign y     = r_s2_y;
    assign cnt_x = r_cnt_x;
    assign cnt_y = r_cnt_y;

    // ------------------------------------------------------------------
    // Completed-transaction counter, free-running wrap
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txn_cnt <= '0;
        end else if (out_valid && out_ready) begin
            r_txn_cnt <= r_txn_cnt + {{(TXN_W-1){1'b0}}, 1'b1};
        end
    end

    assign txn_cnt = r_txn_cnt;

`ifdef LOGIC_FN_SWEEP_EN
    // ------------------------------------------------------------------
    // Truth-table sweep FSM and checker
    // ------------------------------------------------------------------
    sweep_state_t  r_state;
    logic [2:0]    r_k;
    logic [2:0]    r_s1_idx;   // row index travelling alongside stage 1
    logic [2:0]    r_s2_idx;   // row index travelling alongside stage 2
    logic          r_ok;
    logic          r_done;
    logic          r_pass;
    logic          w_match;

    assign w_busy    = (r_state != ST_IDLE);
    assign w_inject  = (r_state == ST_SWEEP);
    assign w_start   = (r_state == ST_IDLE) & sweep_start & ~r_v1 & ~r_v2;
    assign w_sweep_k = r_k;

    assign w_match = (r_s2_x == {WIDTH{fn_x(r_s2_idx[2], r_s2_idx[1], r_s2_idx[0])}})
                  && (r_s2_y == {WIDTH{fn_y(r_s2_idx[2], r_s2_idx[1])}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_k      <= 3'd0;
            r_s1_idx <= 3'd0;
            r_s2_idx <= 3'd0;
            r_ok     <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_en) begin
                r_s1_idx <= r_k;
                r_s2_idx <= r_s1_idx;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_SWEEP;
                        r_k     <= 3'd0;
                        r_ok    <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    r_k <= r_k + 3'd1;
                    if (r_k == 3'd7) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!r_v1 && !r_v2) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= r_ok;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Sweep rows reach stage 2 already while still injecting
            if ((r_state == ST_SWEEP || r_state == ST_DRAIN) && r_v2 && !w_match) begin
                r_ok <= 1'b0;
            end
        end
    end

    assign sweep_busy = w_busy;
    assign sweep_done = r_done;
    assign sweep_pass = r_pass;
`else
    logic w_sweep_start_unused;

    assign w_sweep_start_unused = sweep_start;
    assign w_busy     = 1'b0;
    assign w_inject   = 1'b0;
    assign w_start    = 1'b0;
    assign w_sweep_k  = 3'd0;
    assign sweep_busy = 1'b0;
    assign sweep_done = 1'b0;
    assign sweep_pass = 1'b0;
`endif

endmodule : logic_fn_pipe
`default_nettype wire

// File: tb/tb_logic_fn_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_fn_pipe
// Description : Self-checking bench for logic_fn_pipe. Every accepted beat is
//               turned into an expected result by a bitwise reference model
//               and queued; every output handshake is checked against the
//               queue head. Directed steps cover reset, a known vector,
//               backpressure, streaming, counter wrap, sweep and mid-sweep
//               reset (sweep steps depend on LOGIC_FN_SWEEP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_fn_pipe;

    localparam int W  = 8;
    localparam int CB = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b, c;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  x, y;
    logic [CB-1:0] cnt_x, cnt_y;
    logic [15:0]   txn_cnt;
    logic          sweep_start;
    logic          sweep_busy, sweep_done, sweep_pass;

    logic_fn_pipe #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .c           (c),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .x           (x),
        .y           (y),
        .cnt_x       (cnt_x),
        .cnt_y       (cnt_y),
        .txn_cnt     (txn_cnt),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .sweep_pass  (sweep_pass)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] ex;
        logic [W-1:0] ey;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   exp_txn = 0;

    function automatic logic [W-1:0] ref_x(input logic [W-1:0] ia, ib, ic);
        return ~(ic ^ (ia | ib));
    endfunction

    function automatic logic [W-1:0] ref_y(input logic [W-1:0] ia, ib);
        return (ia | ib) & (~(ia & ib) ^ (ia | ib));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One clock: observe handshakes at the falling edge, return after the
    // rising edge so the caller drives the next cycle's inputs.
    task automatic tick(output bit acc, output bit got);
        exp_t e;
        @(negedge clk);
        acc = in_valid && in_ready;
        got = out_valid && out_ready;
        if (acc) q.push_back('{ref_x(a, b, c), ref_y(a, b)});
        if (got) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("x", 32'(x), 32'(e.ex));
                chk("y", 32'(y), 32'(e.ey));
                chk("cnt_x", 32'(cnt_x), 32'($countones(e.ex)));
                chk("cnt_y", 32'(cnt_y), 32'($countones(e.ey)));
                exp_txn = (exp_txn + 1) & 32'hFFFF;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    bit           acc, got, seen;
    int           n_acc, n_out, first_out, last_out, issued, n;
    logic [W-1:0] hold_x;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sweep_start = 1'b0;
        a = '0; b = '0; c = '0;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_cnt", 32'({cnt_x, cnt_y}), 32'd0);
        chk("rst_txn", 32'(txn_cnt), 32'd0);
        chk("rst_sweep", 32'({sweep_busy, sweep_done, sweep_pass}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // ---------------- single known beat ----------------
        a = 8'hF0; b = 8'hCC; c = 8'hAA; in_valid = 1'b1; out_ready = 1'b1;
        tick(acc, got);
        chk("single_acc", 32'(acc), 32'd1);
        in_valid = 1'b0;
        chk("single_early", 32'(out_valid), 32'd0);
        tick(acc, got);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_x", 32'(x), 32'hA9);
        chk("single_y", 32'(y), 32'hC0);
        chk("single_cnt_x", 32'(cnt_x), 32'd4);
        chk("single_cnt_y", 32'(cnt_y), 32'd2);
        tick(acc, got);
        chk("single_txn", 32'(txn_cnt), 32'd1);

        // ---------------- backpressure ----------------
        out_ready = 1'b0; in_valid = 1'b1; n_acc = 0;
        a = W'($urandom); b = W'($urandom); c = W'($urandom);
        for (int i = 0; i < 5; i++) begin
            tick(acc, got);
            if (acc) begin
                n_acc++;
                a = W'($urandom); b = W'($urandom); c = W'($urandom);
            end
        end
        chk("bp_accepted", 32'(n_acc), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        hold_x = x;
        tick(acc, got);
        chk("bp_hold_x", 32'(x), 32'(hold_x));
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(acc, got);
            if (acc) in_valid = 1'b0;
        end
        chk("bp_drained", 32'(q.size()), 32'd0);
        chk("bp_txn", 32'(txn_cnt), 32'd4);

        // ---------------- streaming ----------------
        issued = 0; n_out = 0; first_out = -1; last_out = -1;
        for (int t = 0; t < 16; t++) begin
            if (issued < 10) begin
                in_valid = 1'b1;
                a = W'($urandom); b = W'($urandom); c = W'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            tick(acc, got);
            if (acc) issued++;
            if (got) begin
                if (first_out < 0) first_out = t;
                last_out = t;
                n_out++;
            end
        end
        chk("stream_issued", 32'(issued), 32'd10);
        chk("stream_outs", 32'(n_out), 32'd10);
        chk("stream_first", 32'(first_out), 32'd2);
        chk("stream_span", 32'(last_out - first_out), 32'd9);
        chk("stream_txn", 32'(txn_cnt), 32'd14);

        // ---------------- random valid/ready ----------------
        for (int t = 0; t < 60; t++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            tick(acc, got);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick(acc, got);
        chk("rand_drained", 32'(q.size()), 32'd0);
        chk("rand_txn", 32'(txn_cnt), 32'(exp_txn));

        // ---------------- counter wrap ----------------
        force dut.r_txn_cnt = 16'hFFFF;
        #1;
        release dut.r_txn_cnt;
        exp_txn = 32'hFFFF;
        chk("wrap_preload", 32'(txn_cnt), 32'hFFFF);
        in_valid = 1'b1; a = W'($urandom); b = W'($urandom); c = W'($urandom);
        tick(acc, got);
        in_valid = 1'b0;
        repeat (3) tick(acc, got);
        chk("wrap_txn", 32'(txn_cnt), 32'd0);

`ifdef LOGIC_FN_SWEEP_EN
        // ---------------- sweep, healthy datapath ----------------
        sweep_start = 1'b1;
        tick(acc, got);
        sweep_start = 1'b0;
        chk("sweep_busy", 32'(sweep_busy), 32'd1);
        chk("sweep_in_ready", 32'(in_ready), 32'd0);
        n = 0;
        while (!sweep_done && n < 30) begin
            tick(acc, got);
            n++;
        end
        chk("sweep_latency", 32'(n), 32'd11);
        chk("sweep_pass", 32'(sweep_pass), 32'd1);
        chk("sweep_txn", 32'(txn_cnt), 32'd0);
        tick(acc, got);
        chk("sweep_idle", 32'({sweep_busy, sweep_done}), 32'd0);
        chk("sweep_pass_hold", 32'(sweep_pass), 32'd1);

        // ---------------- sweep, corrupted stage 1 ----------------
        sweep_start = 1'b1;
        tick(acc, got);
        sweep_start = 1'b0;
        force dut.r_s1_x = '0;
        n = 0;
        while (!sweep_done && n < 30) begin
            tick(acc, got);
            n++;
        end
        release dut.r_s1_x;
        chk("fault_latency", 32'(n), 32'd11);
        chk("fault_pass", 32'(sweep_pass), 32'd0);
        tick(acc, got);

        // ---------------- reset during drain ----------------
        sweep_start = 1'b1;
        tick(acc, got);
        sweep_start = 1'b0;
        repeat (9) tick(acc, got);
        chk("mid_busy", 32'(sweep_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(sweep_busy), 32'd0);
        chk("mid_rst_done", 32'(sweep_done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        exp_txn = 0;
        seen = 1'b0;
        repeat (15) begin
            tick(acc, got);
            seen |= sweep_done | sweep_busy;
        end
        chk("mid_no_done", 32'(seen), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
`else
        // ---------------- sweep absent: request ignored ----------------
        sweep_start = 1'b1;
        tick(acc, got);
        sweep_start = 1'b0;
        seen = 1'b0;
        repeat (14) begin
            tick(acc, got);
            seen |= sweep_busy | sweep_done | sweep_pass;
        end
        chk("nosweep_status", 32'(seen), 32'd0);
        chk("nosweep_in_ready", 32'(in_ready), 32'd1);

        // ---------------- asynchronous reset mid-stream ----------------
        in_valid = 1'b1; out_ready = 1'b0;
        a = W'($urandom); b = W'($urandom); c = W'($urandom);
        repeat (2) tick(acc, got);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_txn", 32'(txn_cnt), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        exp_txn = 0;
`endif

        // ---------------- post-reset beat ----------------
        out_ready = 1'b1; in_valid = 1'b1;
        a = W'($urandom); b = W'($urandom); c = W'($urandom);
        tick(acc, got);
        in_valid = 1'b0;
        repeat (3) tick(acc, got);
        chk("post_txn", 32'(txn_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_logic_fn_pipe
`default_nettype wire
